// File: rtl/m62_rom_loader_if.sv
// ioctl download stream plus the two SDRAM toggle req/ack ports of the ROM loader.
interface m62_rom_loader_if;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        port1_req;
    logic        port1_ack;
    logic [22:0] port1_a;
    logic [1:0]  port1_ds;
    logic        port2_req;
    logic        port2_ack;
    logic [22:0] port2_a;
    logic [1:0]  port2_ds;
    logic [15:0] port_d;

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        input  port1_ack, port2_ack,
        output ioctl_wait, port1_req, port1_a, port1_ds,
        output port2_req, port2_a, port2_ds, port_d
    );

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        output port1_ack, port2_ack,
        input  ioctl_wait, port1_req, port1_a, port1_ds,
        input  port2_req, port2_a, port2_ds, port_d
    );
endinterface

// File: rtl/m62_rom_loader.sv
// ROM download front end: routes ioctl bytes to SDRAM ports, sound/PROM strobes and latches,
// stalling the HPS until SDRAM acknowledges each ROM byte.
module m62_rom_loader #(
    parameter logic [24:0] SND_BASE  = 25'h20000,
    parameter logic [24:0] GFX_BASE  = 25'h30000,
    parameter logic [24:0] PROM_BASE = 25'hA0000,
    parameter logic [24:0] PROM_SIZE = 25'h00920,
    parameter int unsigned TIMEOUT   = 1023
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    m62_rom_loader_if.slave bus,
    output logic        snd_wr,
    output logic [15:0] snd_addr,
    output logic [7:0]  snd_data,
    output logic        prom_wr,
    output logic [11:0] prom_addr,
    output logic [7:0]  prom_data,
    output logic [7:0]  core_mod,
    output logic [63:0] dip_sw,
    output logic        rom_loaded,
    output logic        dl_error,
    output logic [24:0] byte_count
);
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]       state, state_d;
    logic             wr_prev, dl_prev, end_pend, p2_used;
    logic [24:0]      addr_q;
    logic [7:0]       data_q;
    logic [TMR_W-1:0] tmr;

    logic        accept_c, rom_idx_c, dl_rise_c, dl_fall_c, acks_done_c;
    logic        done_c, timeout_c;
    logic [23:0] p2_off_c;

    assign accept_c    = bus.ioctl_wr & ~wr_prev & bus.ioctl_download;
    assign rom_idx_c   = (bus.ioctl_index == 8'd0);
    assign dl_rise_c   = bus.ioctl_download & ~dl_prev & rom_idx_c;
    assign dl_fall_c   = ~bus.ioctl_download & dl_prev & rom_idx_c;
    assign acks_done_c = (bus.port1_ack == bus.port1_req) &&
                         (!p2_used || (bus.port2_ack == bus.port2_req));
    assign p2_off_c    = 24'(bus.ioctl_addr - GFX_BASE);

    // next-state logic
    always_comb begin
        state_d   = state;
        done_c    = 1'b0;
        timeout_c = 1'b0;
        case (state)
            S_IDLE:  if (accept_c && rom_idx_c) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (acks_done_c) begin
                    done_c  = 1'b1;
                    state_d = S_IDLE;
                end else if (tmr == TMR_LAST) begin
                    timeout_c = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_d;
    end

    // datapath and status registers
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_prev        <= 1'b0;
            dl_prev        <= 1'b0;
            end_pend       <= 1'b0;
            p2_used        <= 1'b0;
            addr_q         <= '0;
            data_q         <= '0;
            tmr            <= '0;
            bus.ioctl_wait <= 1'b0;
            bus.port1_req  <= 1'b0;
            bus.port1_a    <= '0;
            bus.port1_ds   <= '0;
            bus.port2_req  <= 1'b0;
            bus.port2_a    <= '0;
            bus.port2_ds   <= '0;
            bus.port_d     <= '0;
            snd_wr         <= 1'b0;
            snd_addr       <= '0;
            snd_data       <= '0;
            prom_wr        <= 1'b0;
            prom_addr      <= '0;
            prom_data      <= '0;
            core_mod       <= '0;
            dip_sw         <= '0;
            rom_loaded     <= 1'b0;
            dl_error       <= 1'b0;
            byte_count     <= '0;
        end else begin
            wr_prev <= bus.ioctl_wr;
            dl_prev <= bus.ioctl_download;
            snd_wr  <= 1'b0;
            prom_wr <= 1'b0;

            if (dl_rise_c) begin
                byte_count <= '0;
                dl_error   <= 1'b0;
                end_pend   <= 1'b0;
            end

            if (accept_c && bus.ioctl_index == 8'd1)
                core_mod <= bus.ioctl_dout;
            if (accept_c && bus.ioctl_index == 8'd254 && bus.ioctl_addr[24:3] == 22'd0)
                dip_sw[{bus.ioctl_addr[2:0], 3'b000} +: 8] <= bus.ioctl_dout;

            if (accept_c && rom_idx_c) begin
                if (state == S_IDLE) begin
                    addr_q         <= bus.ioctl_addr;
                    data_q         <= bus.ioctl_dout;
                    bus.ioctl_wait <= 1'b1;
                    bus.port1_a    <= bus.ioctl_addr[23:1];
                    bus.port1_ds   <= {bus.ioctl_addr[0], ~bus.ioctl_addr[0]};
                    bus.port2_a    <= p2_off_c[23:1];
                    bus.port2_ds   <= {p2_off_c[0], ~p2_off_c[0]};
                    bus.port_d     <= {bus.ioctl_dout, bus.ioctl_dout};
                    if (dl_rise_c)        byte_count <= 25'd1;
                    else if (~&byte_count) byte_count <= byte_count + 25'd1;
                end else begin
                    dl_error <= 1'b1;
                end
            end

            if (state == S_ISSUE) begin
                tmr           <= '0;
                bus.port1_req <= ~bus.port1_req;
                p2_used       <= (addr_q >= GFX_BASE);
                if (addr_q >= GFX_BASE) bus.port2_req <= ~bus.port2_req;
                if (addr_q >= SND_BASE && addr_q < GFX_BASE) begin
                    snd_wr   <= 1'b1;
                    snd_addr <= addr_q[15:0];
                    snd_data <= data_q;
                end
                if (addr_q >= PROM_BASE && addr_q < PROM_BASE + PROM_SIZE) begin
                    prom_wr   <= 1'b1;
                    prom_addr <= 12'(addr_q - PROM_BASE);
                    prom_data <= data_q;
                end
            end

            if (state == S_WAIT) begin
                tmr <= tmr + TMR_W'(1);
                if (done_c || timeout_c) bus.ioctl_wait <= 1'b0;
                if (timeout_c)           dl_error       <= 1'b1;
            end

            // end of download is judged only once no handshake is in flight
            if (dl_fall_c && state != S_IDLE) begin
                end_pend <= 1'b1;
            end else if ((dl_fall_c || end_pend) && state == S_IDLE) begin
                end_pend <= 1'b0;
                if (byte_count != 25'd0 && !dl_error) rom_loaded <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_m62_rom_loader.sv
// Directed bench for m62_rom_loader with a delayed-echo SDRAM ack model on both ports.
module tb_m62_rom_loader;
    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        snd_wr, prom_wr, rom_loaded, dl_error;
    logic [15:0] snd_addr;
    logic [7:0]  snd_data, prom_data, core_mod;
    logic [11:0] prom_addr;
    logic [63:0] dip_sw;
    logic [24:0] byte_count;

    m62_rom_loader_if bus();

    m62_rom_loader dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .bus(bus),
        .snd_wr(snd_wr), .snd_addr(snd_addr), .snd_data(snd_data),
        .prom_wr(prom_wr), .prom_addr(prom_addr), .prom_data(prom_data),
        .core_mod(core_mod), .dip_sw(dip_sw), .rom_loaded(rom_loaded),
        .dl_error(dl_error), .byte_count(byte_count)
    );

    always #5 clk_sys = ~clk_sys;

    // SDRAM model: ack echoes req after a programmable number of cycles; port1 can be frozen
    logic [7:0] p1_pipe, p2_pipe;
    logic [8:0] p1_hist, p2_hist;
    logic       p1_ack, p2_ack, p1_hold;
    int         p1_dly, p2_dly;
    assign p1_hist = {p1_pipe, bus.port1_req};
    assign p2_hist = {p2_pipe, bus.port2_req};
    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            p1_pipe <= '0; p2_pipe <= '0; p1_ack <= 1'b0; p2_ack <= 1'b0;
        end else begin
            p1_pipe <= p1_hist[7:0];
            p2_pipe <= p2_hist[7:0];
            if (!p1_hold) p1_ack <= p1_hist[p1_dly-1];
            p2_ack <= p2_hist[p2_dly-1];
        end
    end
    assign bus.port1_ack = p1_ack;
    assign bus.port2_ack = p2_ack;

    int n_cmp = 0;
    int n_bad = 0;
    int wc, ns, np, t1, t2;
    logic [15:0] snd_a_seen;
    logic [7:0]  snd_d_seen;
    logic [11:0] prom_a_seen;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
        end
    endtask

    // one byte, wr held until wait drops; counts wait cycles, strobes and req toggles
    task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
        logic r1, r2;
        @(negedge clk_sys);
        r1 = bus.port1_req; r2 = bus.port2_req;
        bus.ioctl_addr = a; bus.ioctl_dout = d; bus.ioctl_wr = 1'b1;
        wc = 0; ns = 0; np = 0; t1 = 0; t2 = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_sys);
            if (bus.port1_req != r1) begin t1++; r1 = bus.port1_req; end
            if (bus.port2_req != r2) begin t2++; r2 = bus.port2_req; end
            if (snd_wr)  begin ns++; snd_a_seen = snd_addr; snd_d_seen = snd_data; end
            if (prom_wr) begin np++; prom_a_seen = prom_addr; end
            if (bus.ioctl_wait) wc++;
            else break;
        end
        chk("wait_released", 64'(bus.ioctl_wait), 64'(0));
        bus.ioctl_wr = 1'b0;
        repeat (10) @(negedge clk_sys);
    endtask

    task automatic dl_start(input logic [7:0] idx);
        @(negedge clk_sys);
        bus.ioctl_index = idx;
        @(negedge clk_sys);
        bus.ioctl_download = 1'b1;
        @(negedge clk_sys);
    endtask

    task automatic dl_end();
        @(negedge clk_sys);
        bus.ioctl_download = 1'b0;
        repeat (2) @(negedge clk_sys);
    endtask

    initial begin
        reset_n = 1'b0;
        bus.ioctl_download = 1'b0; bus.ioctl_index = 8'd0; bus.ioctl_wr = 1'b0;
        bus.ioctl_addr = '0; bus.ioctl_dout = '0;
        p1_hold = 1'b0; p1_dly = 1; p2_dly = 1;
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);
        chk("rst_wait", 64'(bus.ioctl_wait), 64'(0));
        chk("rst_reqs", 64'({bus.port1_req, bus.port2_req}), 64'(0));
        chk("rst_status", 64'({rom_loaded, dl_error, byte_count}), 64'(0));
        chk("rst_core_mod", 64'(core_mod), 64'(0));
        chk("rst_dip", dip_sw, 64'(0));

        // ack withheld: abort after TIMEOUT cycles in WAIT_ACK
        dl_start(8'd0);
        p1_hold = 1'b1;
        send_byte(25'h10, 8'h11);
        chk("to_wait_cycles", 64'(wc), 64'(1024));
        chk("to_dl_error", 64'(dl_error), 64'(1));
        chk("to_byte_count", 64'(byte_count), 64'(1));
        dl_end();
        chk("to_rom_loaded", 64'(rom_loaded), 64'(0));
        p1_hold = 1'b0;
        repeat (5) @(negedge clk_sys);

        // second wr edge while waiting for ack is an overrun
        p1_dly = 8;
        dl_start(8'd0);
        chk("rise_clr_err", 64'(dl_error), 64'(0));
        chk("rise_clr_cnt", 64'(byte_count), 64'(0));
        bus.ioctl_addr = 25'h40; bus.ioctl_dout = 8'h22; bus.ioctl_wr = 1'b1;
        repeat (3) @(negedge clk_sys);
        bus.ioctl_wr = 1'b0;
        @(negedge clk_sys);
        bus.ioctl_wr = 1'b1;
        @(negedge clk_sys);
        chk("ovr_dl_error", 64'(dl_error), 64'(1));
        chk("ovr_byte_count", 64'(byte_count), 64'(1));
        for (int i = 0; i < 50 && bus.ioctl_wait; i++) @(negedge clk_sys);
        chk("ovr_wait_drop", 64'(bus.ioctl_wait), 64'(0));
        bus.ioctl_wr = 1'b0;
        repeat (12) @(negedge clk_sys);
        dl_end();
        chk("ovr_rom_loaded", 64'(rom_loaded), 64'(0));

        // clean download with directed bytes
        dl_start(8'd0);
        p1_dly = 4; p2_dly = 1;
        send_byte(25'h00005, 8'hA5);
        chk("b5_wait_cycles", 64'(wc), 64'(6));
        chk("b5_toggles", 64'({t1[3:0], t2[3:0]}), 64'(8'h10));
        chk("b5_port1_a", 64'(bus.port1_a), 64'(23'h2));
        chk("b5_port1_ds", 64'(bus.port1_ds), 64'(2'b10));
        chk("b5_port_d", 64'(bus.port_d), 64'(16'hA5A5));
        chk("b5_strobes", 64'({ns[3:0], np[3:0]}), 64'(0));

        p1_dly = 2; p2_dly = 5;
        send_byte(25'h30001, 8'h3C);
        chk("g1_toggles", 64'({t1[3:0], t2[3:0]}), 64'(8'h11));
        chk("g1_wait_p2late", 64'(wc), 64'(7));
        chk("g1_port2_a", 64'(bus.port2_a), 64'(0));
        chk("g1_port2_ds", 64'(bus.port2_ds), 64'(2'b10));
        chk("g1_port1_a", 64'(bus.port1_a), 64'(23'h18000));
        p1_dly = 5; p2_dly = 2;
        send_byte(25'h30003, 8'h3D);
        chk("g3_wait_p1late", 64'(wc), 64'(7));
        chk("g3_port2_a", 64'(bus.port2_a), 64'(1));

        p1_dly = 1; p2_dly = 1;
        send_byte(25'h2ABCD, 8'h5E);
        chk("snd_strobes", 64'(ns), 64'(1));
        chk("snd_addr", 64'(snd_a_seen), 64'(16'hABCD));
        chk("snd_data", 64'(snd_d_seen), 64'(8'h5E));
        chk("snd_no_port2", 64'(t2), 64'(0));
        chk("snd_wait_min", 64'(wc), 64'(3));

        send_byte(25'hA0910, 8'h77);
        chk("prom_strobes", 64'(np), 64'(1));
        chk("prom_addr", 64'(prom_a_seen), 64'(12'h910));
        chk("prom_port2", 64'(t2), 64'(1));
        send_byte(25'hA0920, 8'h78);
        chk("prom_end_none", 64'(np), 64'(0));
        chk("prom_end_snd", 64'(ns), 64'(0));

        for (int k = 0; k < 32; k++) send_byte(25'(k), 8'(k));
        chk("burst_count", 64'(byte_count), 64'(25'h26));
        chk("burst_err", 64'(dl_error), 64'(0));
        @(negedge clk_sys);
        bus.ioctl_download = 1'b0;
        chk("end_pre_loaded", 64'(rom_loaded), 64'(0));
        @(negedge clk_sys);
        chk("end_rom_loaded", 64'(rom_loaded), 64'(1));
        repeat (2) @(negedge clk_sys);

        // latched indices never stall
        dl_start(8'd1);
        send_byte(25'h0, 8'h5A);
        chk("cm_value", 64'(core_mod), 64'(8'h5A));
        chk("cm_no_wait", 64'(wc), 64'(0));
        dl_end();
        dl_start(8'd254);
        send_byte(25'h3, 8'h7F);
        chk("dip_no_req", 64'(t1), 64'(0));
        send_byte(25'h8, 8'h11);
        chk("dip_value", dip_sw, 64'h0000_0000_7F00_0000);
        dl_end();
        chk("dip_keep_loaded", 64'(rom_loaded), 64'(1));

        // async reset in the middle of a handshake
        dl_start(8'd0);
        p1_hold = 1'b1;
        bus.ioctl_addr = 25'h31000; bus.ioctl_dout = 8'h99; bus.ioctl_wr = 1'b1;
        repeat (5) @(negedge clk_sys);
        chk("pre_rst_wait", 64'(bus.ioctl_wait), 64'(1));
        #2 reset_n = 1'b0;
        #1;
        chk("arst_wait_reqs", 64'({bus.ioctl_wait, bus.port1_req, bus.port2_req}), 64'(0));
        chk("arst_status", 64'({rom_loaded, dl_error, byte_count}), 64'(0));
        chk("arst_bus", 64'({bus.port1_a, bus.port_d}), 64'(0));
        chk("arst_latches", 64'({core_mod, dip_sw[31:24]}), 64'(0));
        bus.ioctl_wr = 1'b0; bus.ioctl_download = 1'b0; p1_hold = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (3) @(negedge clk_sys);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
